// File: rtl/vram_pkg.sv
// Shared constants and grant-owner encoding for the tile-map VRAM arbiter
// and its helpers (tile_addr_calc, later the sprite collision logic).
package vram_pkg;

  localparam int unsigned DATA_W     = 4;
  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned MAP_W      = 40;
  localparam int unsigned MAP_H      = 30;
  localparam int unsigned TILE_SHIFT = 4;
  localparam int unsigned VRAM_DEPTH = MAP_W * MAP_H;
  localparam int unsigned X_W        = 10;
  localparam int unsigned Y_W        = 9;

  // Registered owner of the RAM port; only routes the N+1 read response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    G0   = 2'd2,
    G1   = 2'd3
  } owner_e;

endpackage

// File: rtl/tile_addr_calc.sv
// Pixel (x,y) to tile-map address: (y>>TILE_SHIFT)*MAP_W + (x>>TILE_SHIFT).
// Ports:
//   px_x_i    pixel x coordinate
//   px_y_i    pixel y coordinate
//   tile_addr_o  linear tile address (max 1199 inside the visible area)
module tile_addr_calc
  import vram_pkg::*;
(
  input  logic [X_W-1:0]    px_x_i,
  input  logic [Y_W-1:0]    px_y_i,
  output logic [ADDR_W-1:0] tile_addr_o
);

  localparam int unsigned COL_W = X_W - TILE_SHIFT;
  localparam int unsigned ROW_W = Y_W - TILE_SHIFT;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  assign col = COL_W'(px_x_i >> TILE_SHIFT);
  assign row = ROW_W'(px_y_i >> TILE_SHIFT);

  // row*40 as row*32 + row*8 keeps it to shifts and adds.
  assign tile_addr_o = (ADDR_W'(row) << 5) + (ADDR_W'(row) << 3) + ADDR_W'(col);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port tile-map RAM arbiter: VGA scanout fetch has absolute priority on
// pixel-strobe cycles, the two game clients (g0 pacman, g1 ghosts) share the
// remaining cycles round-robin. Grant is combinational; read responses arrive
// one cycle after the grant, matching the RAM's 1-cycle read latency.
// Optional: VRAM_VBLANK_LOCK_EN -- game writes only eligible while vblank=1.
// Ports:
//   clk, rst                       50 MHz clock, synchronous active-high reset
//   pix_stb, disp_active, vblank   VGA timing inputs
//   disp_x, disp_y                 current beam pixel position
//   disp_tile, disp_tile_vld       fetched tile code and its valid pulse
//   gN_valid/we/addr/wdata/ready   game client request handshake (N=0,1)
//   gN_rvalid, g_rdata             game read response (shared data bus)
//   ram_addr/we/wdata, ram_rdata   tile RAM port
module vram_arbiter
  import vram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_stb,
  input  logic              disp_active,
  input  logic              vblank,
  input  logic [X_W-1:0]    disp_x,
  input  logic [Y_W-1:0]    disp_y,
  output logic [DATA_W-1:0] disp_tile,
  output logic              disp_tile_vld,
  input  logic              g0_valid,
  input  logic              g0_we,
  input  logic [ADDR_W-1:0] g0_addr,
  input  logic [DATA_W-1:0] g0_wdata,
  output logic              g0_ready,
  output logic              g0_rvalid,
  input  logic              g1_valid,
  input  logic              g1_we,
  input  logic [ADDR_W-1:0] g1_addr,
  input  logic [DATA_W-1:0] g1_wdata,
  output logic              g1_ready,
  output logic              g1_rvalid,
  output logic [DATA_W-1:0] g_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  owner_e              owner_q, owner_d;
  logic                rr_q, rr_d;        // 0: g0 wins a tie, 1: g1 wins
  logic                rd_q, rd_d;        // granted game op was a read
  logic                oor_q, oor_d;      // granted game address out of range
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   disp_tile_q, disp_tile_d;
  logic [DATA_W-1:0]   g_rdata_q, g_rdata_d;

  logic [ADDR_W-1:0]   disp_addr;
  logic                disp_req;
  logic                g0_elig, g1_elig;
  logic                game_we;
  logic [ADDR_W-1:0]   game_addr;
  logic [DATA_W-1:0]   game_wdata;

  tile_addr_calc u_tile_addr (
    .px_x_i      (disp_x),
    .px_y_i      (disp_y),
    .tile_addr_o (disp_addr)
  );

  assign disp_req = pix_stb && disp_active;

`ifdef VRAM_VBLANK_LOCK_EN
  // Writes wait for vblank so the visible frame never tears; reads always go.
  assign g0_elig = g0_valid && (!g0_we || vblank);
  assign g1_elig = g1_valid && (!g1_we || vblank);
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign g0_elig = g0_valid;
  assign g1_elig = g1_valid;
`endif

  // State and holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= IDLE;
      rr_q        <= 1'b0;
      rd_q        <= 1'b0;
      oor_q       <= 1'b0;
      ram_addr_q  <= '0;
      disp_tile_q <= '0;
      g_rdata_q   <= '0;
    end else begin
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      rd_q        <= rd_d;
      oor_q       <= oor_d;
      ram_addr_q  <= ram_addr_d;
      disp_tile_q <= disp_tile_d;
      g_rdata_q   <= g_rdata_d;
    end
  end

  // Grant selection, RAM port drive and N+1 response routing.
  always_comb begin
    owner_d       = IDLE;
    rr_d          = rr_q;
    rd_d          = 1'b0;
    oor_d         = 1'b0;
    game_we       = 1'b0;
    game_addr     = '0;
    game_wdata    = '0;
    g0_ready      = 1'b0;
    g1_ready      = 1'b0;
    ram_addr      = ram_addr_q;
    ram_we        = 1'b0;
    ram_wdata     = '0;
    disp_tile_vld = 1'b0;
    disp_tile     = disp_tile_q;
    g0_rvalid     = 1'b0;
    g1_rvalid     = 1'b0;
    g_rdata       = g_rdata_q;

    // Response for the grant made last cycle.
    case (owner_q)
      DISP: begin
        disp_tile_vld = 1'b1;
        disp_tile     = ram_rdata;
      end
      G0: if (rd_q) begin
        g0_rvalid = 1'b1;
        g_rdata   = oor_q ? '0 : ram_rdata;
      end
      G1: if (rd_q) begin
        g1_rvalid = 1'b1;
        g_rdata   = oor_q ? '0 : ram_rdata;
      end
      default: ;
    endcase

    if (disp_req) begin
      owner_d = DISP;
    end else if (g0_elig && (!g1_elig || !rr_q)) begin
      owner_d = G0;
    end else if (g1_elig) begin
      owner_d = G1;
    end

    case (owner_d)
      DISP: ram_addr = disp_addr;
      G0: begin
        g0_ready   = 1'b1;
        rr_d       = 1'b1;
        game_we    = g0_we;
        game_addr  = g0_addr;
        game_wdata = g0_wdata;
      end
      G1: begin
        g1_ready   = 1'b1;
        rr_d       = 1'b0;
        game_we    = g1_we;
        game_addr  = g1_addr;
        game_wdata = g1_wdata;
      end
      default: ;
    endcase

    // Out-of-range ops are acknowledged but never touch the RAM contents.
    if (owner_d == G0 || owner_d == G1) begin
      ram_addr  = game_addr;
      oor_d     = !(game_addr < ADDR_W'(VRAM_DEPTH));
      ram_we    = game_we && !oor_d;
      ram_wdata = game_we ? game_wdata : '0;
      rd_d      = !game_we;
    end

    ram_addr_d  = ram_addr;
    disp_tile_d = disp_tile;
    g_rdata_d   = g_rdata;

    // Outputs are forced low while in reset; an in-flight response is dropped.
    if (rst) begin
      g0_ready      = 1'b0;
      g1_ready      = 1'b0;
      ram_addr      = '0;
      ram_we        = 1'b0;
      ram_wdata     = '0;
      disp_tile_vld = 1'b0;
      disp_tile     = '0;
      g0_rvalid     = 1'b0;
      g1_rvalid     = 1'b0;
      g_rdata       = '0;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised scoreboard bench for vram_arbiter with a behavioural tile RAM.
module tb_vram_arbiter;

`ifdef VRAM_VBLANK_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct packed {
    bit        rst;
    bit        r0;
    bit        r1;
    bit        we;
    logic [10:0] addr;
    logic [3:0]  wdata;
  } cyc_t;

  typedef struct {
    int due;
    int data;
  } rsp_t;

  typedef struct {
    bit we;
    int addr;
    int wdata;
  } req_t;

  logic        clk, rst, pix_stb, disp_active, vblank;
  logic [9:0]  disp_x;
  logic [8:0]  disp_y;
  logic [3:0]  disp_tile;
  logic        disp_tile_vld;
  logic        g0_valid, g0_we, g0_ready, g0_rvalid;
  logic [10:0] g0_addr;
  logic [3:0]  g0_wdata;
  logic        g1_valid, g1_we, g1_ready, g1_rvalid;
  logic [10:0] g1_addr;
  logic [3:0]  g1_wdata;
  logic [3:0]  g_rdata;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wdata, ram_rdata;

  vram_arbiter dut (
    .clk(clk), .rst(rst), .pix_stb(pix_stb), .disp_active(disp_active),
    .vblank(vblank), .disp_x(disp_x), .disp_y(disp_y),
    .disp_tile(disp_tile), .disp_tile_vld(disp_tile_vld),
    .g0_valid(g0_valid), .g0_we(g0_we), .g0_addr(g0_addr), .g0_wdata(g0_wdata),
    .g0_ready(g0_ready), .g0_rvalid(g0_rvalid),
    .g1_valid(g1_valid), .g1_we(g1_we), .g1_addr(g1_addr), .g1_wdata(g1_wdata),
    .g1_ready(g1_ready), .g1_rvalid(g1_rvalid),
    .g_rdata(g_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state.
  int   ref_mem [0:1199];
  int   m_rr     = 0;
  int   m_last   = 0;
  req_t rq0[$], rq1[$];
  cyc_t cyc_exp[$];
  rsp_t disp_exp[$], rd0_exp[$], rd1_exp[$];

  // Monitor state.
  cyc_t mon_e;
  int   m_disp = 0;
  bit   exp_v;

  logic [3:0] mem [0:1199];

  function automatic int init_val(input int i);
    return (i == 82) ? 5 : ((i * 7 + 3) % 16);
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.we    = 1'($urandom % 2);
    r.addr  = ($urandom % 8 == 0) ? 1200 + int'($urandom % 848) : int'($urandom % 1200);
    r.wdata = int'($urandom % 16);
    return r;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM, 1-cycle read latency; out-of-range reads give F.
  initial begin
    for (int i = 0; i < 1200; i++) mem[i] = 4'(init_val(i));
    ram_rdata <= 4'h0;
    forever begin
      @(posedge clk);
      ram_rdata <= (int'(ram_addr) < 1200) ? mem[int'(ram_addr)] : 4'hF;
      if (ram_we && int'(ram_addr) < 1200) mem[int'(ram_addr)] = ram_wdata;
    end
  end

  // Drive one cycle and push what the spec says must happen.
  task automatic step(input bit r, input bit stb, input bit act, input bit vb,
                      input int x, input int y);
    cyc_t e;
    rsp_t rs;
    req_t q;
    bit   v0, v1, el0, el1;
    int   g, a;
    @(posedge clk);
    #1;
    v0 = rq0.size() > 0;
    v1 = rq1.size() > 0;
    rst = r; pix_stb = stb; disp_active = act; vblank = vb;
    disp_x = 10'(x); disp_y = 9'(y);
    g0_valid = v0; g0_we = v0 ? rq0[0].we : 1'b0;
    g0_addr  = v0 ? 11'(rq0[0].addr) : 11'd0;
    g0_wdata = v0 ? 4'(rq0[0].wdata) : 4'd0;
    g1_valid = v1; g1_we = v1 ? rq1[0].we : 1'b0;
    g1_addr  = v1 ? 11'(rq1[0].addr) : 11'd0;
    g1_wdata = v1 ? 4'(rq1[0].wdata) : 4'd0;
    e = '0;
    if (r) begin
      e.rst = 1'b1;
      disp_exp.delete(); rd0_exp.delete(); rd1_exp.delete();
      m_rr = 0; m_last = 0;
      cyc_exp.push_back(e);
      return;
    end
    el0 = v0 && (!rq0[0].we || vb || !LOCK);
    el1 = v1 && (!rq1[0].we || vb || !LOCK);
    if (stb && act)        g = 2;
    else if (el0 && el1)   g = m_rr;
    else if (el0)          g = 0;
    else if (el1)          g = 1;
    else                   g = 3;
    rs.due = cyc + 1;
    if (g == 2) begin
      a = (y / 16) * 40 + x / 16;
      m_last = a;
      rs.data = ref_mem[a];
      disp_exp.push_back(rs);
    end else if (g < 2) begin
      if (g == 0) begin q = rq0.pop_front(); e.r0 = 1'b1; end
      else        begin q = rq1.pop_front(); e.r1 = 1'b1; end
      a = q.addr;
      m_last = a;
      if (q.we) begin
        if (a < 1200) begin
          e.we = 1'b1;
          e.wdata = 4'(q.wdata);
          ref_mem[a] = q.wdata;
        end
      end else begin
        rs.data = (a < 1200) ? ref_mem[a] : 0;
        if (g == 0) rd0_exp.push_back(rs);
        else        rd1_exp.push_back(rs);
      end
      m_rr = 1 - g;
    end
    e.addr = 11'(m_last);
    cyc_exp.push_back(e);
  endtask

  // Monitor: compares every cycle's port activity and due responses.
  always @(negedge clk) begin
    if (cyc_exp.size() > 0) begin
      mon_e = cyc_exp.pop_front();
      chk("g0_ready", g0_ready, mon_e.r0);
      chk("g1_ready", g1_ready, mon_e.r1);
      chk("ram_we", ram_we, mon_e.we);
      chk("ram_addr", ram_addr, mon_e.addr);
      if (mon_e.we) chk("ram_wdata", ram_wdata, mon_e.wdata);
      if (mon_e.rst) begin
        m_disp = 0;
        chk("rst_g0_rvalid", g0_rvalid, 0);
        chk("rst_g1_rvalid", g1_rvalid, 0);
        chk("rst_disp_vld", disp_tile_vld, 0);
        chk("rst_disp_tile", disp_tile, 0);
        chk("rst_g_rdata", g_rdata, 0);
      end else begin
        exp_v = disp_exp.size() > 0 && disp_exp[0].due == cyc;
        chk("disp_tile_vld", disp_tile_vld, exp_v);
        if (exp_v) begin
          chk("disp_tile", disp_tile, disp_exp[0].data);
          m_disp = disp_exp[0].data;
          void'(disp_exp.pop_front());
        end else begin
          chk("disp_tile_hold", disp_tile, m_disp);
        end
        exp_v = rd0_exp.size() > 0 && rd0_exp[0].due == cyc;
        chk("g0_rvalid", g0_rvalid, exp_v);
        if (exp_v) begin
          chk("g0_rdata", g_rdata, rd0_exp[0].data);
          void'(rd0_exp.pop_front());
        end
        exp_v = rd1_exp.size() > 0 && rd1_exp[0].due == cyc;
        chk("g1_rvalid", g1_rvalid, exp_v);
        if (exp_v) begin
          chk("g1_rdata", g_rdata, rd1_exp[0].data);
          void'(rd1_exp.pop_front());
        end
      end
    end
  end

  initial begin
    req_t r;
    bit   stb, act, rr;
    for (int i = 0; i < 1200; i++) ref_mem[i] = init_val(i);
    rst = 1'b1; pix_stb = 1'b0; disp_active = 1'b0; vblank = 1'b0;
    disp_x = '0; disp_y = '0;
    g0_valid = 1'b0; g0_we = 1'b0; g0_addr = '0; g0_wdata = '0;
    g1_valid = 1'b0; g1_we = 1'b0; g1_addr = '0; g1_wdata = '0;

    // Reset with both clients requesting; first grant goes to g0.
    r.we = 1'b0; r.wdata = 0;
    r.addr = 10; rq0.push_back(r);
    r.addr = 20; rq1.push_back(r);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Directed display fetch at (37,35) -> address 82 holding 5.
    step(1'b0, 1'b1, 1'b1, 1'b0, 37, 35);
    step(1'b0, 1'b0, 1'b1, 1'b0, 38, 35);

    // Both clients reading continuously during active video.
    for (int i = 0; i < 16; i++) begin
      r.we = 1'b0;
      if (rq0.size() == 0) begin r.addr = int'($urandom % 1200); rq0.push_back(r); end
      if (rq1.size() == 0) begin r.addr = int'($urandom % 1200); rq1.push_back(r); end
      step(1'b0, (i % 2) == 0, 1'b1, 1'b0, int'($urandom % 640), int'($urandom % 480));
    end
    rq0.delete(); rq1.delete();
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

    // Boundary addresses 1199 / 1200 from g1.
    r.we = 1'b1; r.addr = 1199; r.wdata = 10; rq1.push_back(r);
    r.we = 1'b0; r.addr = 1199; r.wdata = 0;  rq1.push_back(r);
    r.we = 1'b1; r.addr = 1200; r.wdata = 3;  rq1.push_back(r);
    r.we = 1'b0; r.addr = 1200; r.wdata = 0;  rq1.push_back(r);
    stb = 1'b0;
    for (int k = 0; k < 40 && rq1.size() > 0; k++) begin
      stb = ~stb;
      step(1'b0, stb, 1'b1, 1'b1, int'($urandom % 640), int'($urandom % 480));
    end
    chk("g1_boundary_drain", rq1.size(), 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);

    // Reset right after a g0 read grant drops its response.
    r.we = 1'b0; r.addr = 5; rq0.push_back(r);
    for (int k = 0; k < 10 && rq0.size() > 0; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    chk("g0_read_granted", rq0.size(), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // g0 write outside vblank while g1 keeps reading, then open vblank.
    r.we = 1'b1; r.addr = 300; r.wdata = 7; rq0.push_back(r);
    for (int i = 0; i < 14; i++) begin
      r.we = 1'b0; r.addr = int'($urandom % 1200);
      if (rq1.size() == 0) rq1.push_back(r);
      stb = ~stb;
      step(1'b0, stb, 1'b1, i >= 8, int'($urandom % 640), int'($urandom % 480));
    end
    chk("g0_lock_drain", rq0.size(), 0);
    rq1.delete();

    // Randomised traffic with occasional mid-run resets.
    act = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 64 == 0) act = ~act;
      stb = ~stb;
      if (rq0.size() == 0 && $urandom % 3 != 0) rq0.push_back(rand_req());
      if (rq1.size() == 0 && $urandom % 3 != 0) rq1.push_back(rand_req());
      rr = ($urandom % 500 == 0);
      step(rr, stb, act, ($urandom % 4 == 0),
           act ? int'($urandom % 640) : 640 + int'($urandom % 100),
           act ? int'($urandom % 480) : int'($urandom % 500));
    end

    // Drain: idle until every outstanding request has been served.
    for (int k = 0; k < 20 && (rq0.size() > 0 || rq1.size() > 0); k++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    chk("final_req_drain", rq0.size() + rq1.size(), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    chk("final_rsp_drain", disp_exp.size() + rd0_exp.size() + rd1_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
